riscv_soft_fetch: RTL and testbench

//  Instruction-fetch (PIF/IF) stage of the riscv-soft pipeline. Owns the PC, issues in-order

---
 rtl/riscv_soft_fetch.sv | 111 +++++++++++
 tb/tb_riscv_soft_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order icache reads under a credit
// limit and queues returned words for EX. Redirects flush the queue and squash in-flight reads.
module riscv_soft_fetch #(
    parameter int unsigned        XPR_LEN   = 32,
    parameter logic [XPR_LEN-1:0] RESET_PC  = 32'h0000_0200,
    parameter int unsigned        BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XPR_LEN-1:0] redirect_target,
    input  logic               stall_IF,
    input  logic               icache_req_ready,
    output logic               icache_req_valid,
    output logic [XPR_LEN-1:0] icache_req_addr,
    input  logic               icache_resp_valid,
    input  logic [31:0]        icache_resp_data,
    output logic               inst_valid_IF,
    output logic [31:0]        instruction_IF,
    output logic [XPR_LEN-1:0] pc_IF,
    output logic               kill_IF
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XPR_LEN-1:0] pc_pif;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      q_cnt;
    logic [PW-1:0]      q_rd, q_wr;
    logic [PW-1:0]      pf_rd, pf_wr;
    logic [XPR_LEN-1:0] q_pc  [BUF_DEPTH];
    logic [31:0]        q_inst[BUF_DEPTH];
    logic [XPR_LEN-1:0] pf_pc [BUF_DEPTH];

    logic [CW:0] credit_used;
    logic        fire, resp_ok, resp_keep, resp_drop, pop;

    // Responses already marked for dropping do not hold a queue credit.
    assign credit_used = {1'b0, outstanding} + {1'b0, q_cnt} - {1'b0, drop};

    assign icache_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign icache_req_addr  = pc_pif;
    assign fire             = icache_req_valid && icache_req_ready;

    assign resp_ok   = icache_resp_valid && (outstanding != '0);
    assign resp_drop = resp_ok && (drop != '0);
    assign resp_keep = resp_ok && (drop == '0);

    assign inst_valid_IF  = !reset && (q_cnt != '0);
    assign kill_IF        = !inst_valid_IF;
    assign instruction_IF = inst_valid_IF ? q_inst[q_rd] : NOP;
    assign pc_IF          = inst_valid_IF ? q_pc[q_rd] : '0;
    assign pop            = inst_valid_IF && !stall_IF;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_pif      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the squashed path.
            pc_pif      <= {redirect_target[XPR_LEN-1:2], 2'b00};
            outstanding <= outstanding - CW'(resp_ok);
            drop        <= outstanding - CW'(resp_ok);
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
        end else begin
            if (fire) begin
                pc_pif <= pc_pif + XPR_LEN'(4);
                pf_wr  <= pf_wr + 1'b1;
            end
            outstanding <= outstanding + CW'(fire) - CW'(resp_ok);
            if (resp_drop) begin
                drop <= drop - 1'b1;
            end
            if (resp_keep) begin
                q_wr  <= q_wr + 1'b1;
                pf_rd <= pf_rd + 1'b1;
            end
            if (pop) begin
                q_rd <= q_rd + 1'b1;
            end
            q_cnt <= q_cnt + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid) begin
            if (fire) begin
                pf_pc[pf_wr] <= pc_pif;
            end
            if (resp_keep) begin
                q_pc[q_wr]   <= pf_pc[pf_rd];
                q_inst[q_wr] <= icache_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_soft_fetch.sv
// Bench for riscv_soft_fetch: an in-order icache model with variable latency plus a
// queue-based reference of the fetch stage, checked every cycle on the falling edge.
module tb_riscv_soft_fetch;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0200;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk, reset, redirect_valid, stall_IF, icache_req_ready;
    logic [31:0] redirect_target;
    logic        icache_req_valid, icache_resp_valid;
    logic [31:0] icache_req_addr, icache_resp_data;
    logic        inst_valid_IF, kill_IF;
    logic [31:0] instruction_IF, pc_IF;

    riscv_soft_fetch #(
        .XPR_LEN  (32),
        .RESET_PC (RPC),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .stall_IF         (stall_IF),
        .icache_req_ready (icache_req_ready),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .inst_valid_IF    (inst_valid_IF),
        .instruction_IF   (instruction_IF),
        .pc_IF            (pc_IF),
        .kill_IF          (kill_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic keep; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } bq_t;
    typedef struct { logic [31:0] addr; int due; } ic_t;
    typedef struct {
        logic rst; logic stall; logic rdy;
        logic e_req; logic [31:0] e_addr; logic e_iv; logic [31:0] e_pc;
    } vec_t;

    fl_t         m_fl[$];
    bq_t         m_buf[$];
    ic_t         icq[$];
    logic [31:0] m_pc;
    logic        e_req, e_iv;
    int          cyc, lat, total, bad;
    vec_t        tbl[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_9613;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs and compare DUT outputs with the reference on the falling edge.
    task automatic drive(input logic r, input logic rv, input logic [31:0] t, input logic st,
                         input logic rd);
        int kept;
        reset            = r;
        redirect_valid   = rv;
        redirect_target  = t;
        stall_IF         = st;
        icache_req_ready = rd;
        if (icq.size() > 0 && icq[0].due <= cyc) begin
            icache_resp_valid = 1'b1;
            icache_resp_data  = mem_word(icq[0].addr);
        end else begin
            icache_resp_valid = 1'b0;
            icache_resp_data  = $urandom;
        end
        kept = 0;
        foreach (m_fl[i]) if (m_fl[i].keep) kept++;
        e_req = !r && !rv && ((kept + m_buf.size()) < DEPTH);
        e_iv  = !r && (m_buf.size() > 0);
        @(negedge clk);
        chk("req_valid", {31'b0, icache_req_valid}, {31'b0, e_req});
        if (e_req) chk("req_addr", icache_req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid_IF}, {31'b0, e_iv});
        chk("kill", {31'b0, kill_IF}, {31'b0, !e_iv});
        if (e_iv) begin
            chk("instruction", instruction_IF, m_buf[0].inst);
            chk("pc_IF", pc_IF, m_buf[0].pc);
        end else begin
            chk("instruction_nop", instruction_IF, NOP);
        end
    endtask

    task automatic edge_update();
        logic d_fire, m_fire, resp;
        int   due;
        fl_t  f;
        d_fire = icache_req_valid && icache_req_ready;
        m_fire = e_req && icache_req_ready;
        resp   = icache_resp_valid;
        @(posedge clk);
        if (reset) begin
            icq.delete();
        end else begin
            if (resp) void'(icq.pop_front());
            if (d_fire) begin
                due = cyc + lat;
                if (icq.size() > 0 && due < icq[$].due) due = icq[$].due;
                icq.push_back('{icache_req_addr, due});
            end
        end
        if (reset) begin
            m_pc = RPC;
            m_fl.delete();
            m_buf.delete();
        end else if (redirect_valid) begin
            if (resp && m_fl.size() > 0) void'(m_fl.pop_front());
            foreach (m_fl[i]) m_fl[i].keep = 1'b0;
            m_buf.delete();
            m_pc = {redirect_target[31:2], 2'b00};
        end else begin
            if (e_iv && !stall_IF) void'(m_buf.pop_front());
            if (resp && m_fl.size() > 0) begin
                f = m_fl.pop_front();
                if (f.keep) m_buf.push_back('{f.pc, mem_word(f.pc)});
            end
            if (m_fire) begin
                m_fl.push_back('{m_pc, 1'b1});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] t, input logic st,
                        input logic rd);
        drive(r, rv, t, st, rd);
        edge_update();
    endtask

    initial begin
        bit hit;
        total = 0; bad = 0; cyc = 0; lat = 1; m_pc = RPC;
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; stall_IF = 1'b0;
        icache_req_ready = 1'b1; icache_resp_valid = 1'b0; icache_resp_data = '0;
        @(posedge clk);
        #1;

        // Reset then free-running fetch with a 1-cycle icache; credit limits issue to every
        // other cycle once a word is buffered.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h208, 1'b1, 32'h204};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h20C, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h210, 1'b1, 32'h20C};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rst, 1'b0, 32'h0, tbl[i].stall, tbl[i].rdy);
            chk("tbl_req", {31'b0, icache_req_valid}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk("tbl_addr", icache_req_addr, tbl[i].e_addr);
            chk("tbl_iv", {31'b0, inst_valid_IF}, {31'b0, tbl[i].e_iv});
            if (tbl[i].e_iv) chk("tbl_pc", pc_IF, tbl[i].e_pc);
            edge_update();
        end

        // Stall for 5 cycles: queue fills, requests stop, then drains in order.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall_req_off", {31'b0, icache_req_valid}, 32'h0);
        edge_update();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect with two reads in flight (3-cycle icache).
        lat = 3;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h1002, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("redir_req", {31'b0, icache_req_valid}, 32'h1);
        chk("redir_addr", icache_req_addr, 32'h1000);
        edge_update();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_buf.size() > 0 && icq.size() > 0 && icq[0].due <= cyc) begin
                step(1'b0, 1'b1, 32'h2000, 1'b0, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            end
        end
        chk("redir_pop_hit", {31'b0, hit}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("redir_pop_iv", {31'b0, inst_valid_IF}, 32'h0);
        edge_update();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // icache not ready for 3 cycles: address held at 0x208, queue drains.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("hold_addr", icache_req_addr, 32'h208);
            chk("hold_valid", {31'b0, icache_req_valid}, 32'h1);
            edge_update();
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset mid-stream with reads pending.
        lat = 2;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("post_reset_addr", icache_req_addr, 32'h200);
        chk("post_reset_iv", {31'b0, inst_valid_IF}, 32'h0);
        edge_update();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // PC wrap past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            lat = $urandom_range(1, 4);
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 11) == 0), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
